div_clk_monitor: RTL and testbench

- Downstream checker for the fractional M/N clock divider output.
- Samples the divided clock as a data signal in the source clock domain, with no synchronizer. This is safe because the divider output is a flop on clk_in.
- Measures each output period in clk_in cycles and counts rising edges per M_N-cycle window.
- Flags pattern violations and asserts `locked` once the divider has produced clean windows back to back.

---
 rtl/div_pkg.sv | 13 +
 rtl/div_clk_monitor_if.sv | 24 ++
 rtl/edge_period_meter.sv | 74 +++++++
 rtl/div_clk_monitor.sv | 115 +++++++++++
 tb/tb_div_clk_monitor.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - constants shared by the M/N divider and its output monitor
// Holds the window length, expected edge count, legal period range, lock depth
// and the common counter width/type.
package div_pkg;
    localparam int CW = 8;
    typedef logic [CW-1:0] cnt_t;

    localparam int unsigned WIN       = 22;
    localparam int unsigned EXP_EDGES = 10;
    localparam int unsigned MIN_PER   = 2;
    localparam int unsigned MAX_PER   = 4;
    localparam int unsigned LOCK_WINS = 2;
endpackage

// File: rtl/div_clk_monitor_if.sv
// rtl/div_clk_monitor_if.sv - signal bundle between divider-side stimulus and the monitor
// Inputs to monitor : div_clk (divider output), en (monitor enable), clr (sticky clear)
// Outputs of monitor: period_last, edge_cnt, win_done, period_err, count_err, locked
interface div_clk_monitor_if;
    logic               div_clk;
    logic               en;
    logic               clr;
    div_pkg::cnt_t      period_last;
    div_pkg::cnt_t      edge_cnt;
    logic               win_done;
    logic               period_err;
    logic               count_err;
    logic               locked;

    modport master (
        output div_clk, en, clr,
        input  period_last, edge_cnt, win_done, period_err, count_err, locked
    );

    modport slave (
        input  div_clk, en, clr,
        output period_last, edge_cnt, win_done, period_err, count_err, locked
    );
endinterface

// File: rtl/edge_period_meter.sv
// rtl/edge_period_meter.sv - rising-edge detect and period measurement of div_clk
// clk_in/rst      : source clock, async active-low reset
// div_clk_i       : divider output, a flop on clk_in, so sampled directly
// en_i            : low forces the counter and first-rise state to zero
// rise_o          : combinational rising-edge strobe for the current cycle
// per_evt_o       : illegal period or stuck clock detected this cycle
// period_last_o   : most recent measured period in clk_in cycles
module edge_period_meter
    import div_pkg::*;
(
    input  logic clk_in,
    input  logic rst,
    input  logic div_clk_i,
    input  logic en_i,
    output logic rise_o,
    output logic per_evt_o,
    output cnt_t period_last_o
);
    localparam cnt_t MIN_C   = cnt_t'(MIN_PER);
    localparam cnt_t MAX_C   = cnt_t'(MAX_PER);
    localparam cnt_t STUCK_C = cnt_t'(MAX_PER + 1);
    localparam cnt_t ONE_C   = cnt_t'(1);

    logic div_q;
    cnt_t per_cnt_q, per_cnt_d;
    cnt_t period_last_q, period_last_d;
    logic first_rise_q, first_rise_d;
    logic rise, evt;

    assign rise = div_clk_i & ~div_q;

    always_comb begin
        per_cnt_d     = per_cnt_q;
        period_last_d = period_last_q;
        first_rise_d  = first_rise_q;
        evt           = 1'b0;
        if (!en_i) begin
            per_cnt_d    = '0;
            first_rise_d = 1'b0;
        end else if (rise) begin
            // per_cnt restarts at 1 so that at the next rise it equals the period.
            per_cnt_d    = ONE_C;
            first_rise_d = 1'b1;
            if (first_rise_q) begin
                period_last_d = per_cnt_q;
                evt           = (per_cnt_q < MIN_C) || (per_cnt_q > MAX_C);
            end
        end else begin
            if (per_cnt_q != '1) begin
                per_cnt_d = per_cnt_q + ONE_C;
            end
            // Matching exactly MAX+1 flags a stuck clock once, not every cycle.
            evt = first_rise_q && (per_cnt_q == STUCK_C);
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            div_q         <= 1'b0;
            per_cnt_q     <= '0;
            period_last_q <= '0;
            first_rise_q  <= 1'b0;
        end else begin
            div_q         <= div_clk_i;
            per_cnt_q     <= per_cnt_d;
            period_last_q <= period_last_d;
            first_rise_q  <= first_rise_d;
        end
    end

    assign rise_o        = rise;
    assign per_evt_o     = evt;
    assign period_last_o = period_last_q;
endmodule

// File: rtl/div_clk_monitor.sv
// rtl/div_clk_monitor.sv - window edge counting, sticky errors and lock for the M/N divider output
// clk_in/rst : source clock shared with the divider, async active-low reset
// mon        : slave side of div_clk_monitor_if (div_clk/en/clr in; status out)
module div_clk_monitor
    import div_pkg::*;
(
    input  logic             clk_in,
    input  logic             rst,
    div_clk_monitor_if.slave mon
);
    localparam cnt_t WIN_LAST = cnt_t'(WIN - 1);
    localparam cnt_t EXP_C    = cnt_t'(EXP_EDGES);
    localparam cnt_t LOCK_C   = cnt_t'(LOCK_WINS);
    localparam cnt_t ONE_C    = cnt_t'(1);

    if (WIN == 0 || WIN > 255 || EXP_EDGES > WIN) begin : g_cfg_check
        $error("div_clk_monitor: WIN must be 1..255 and EXP_EDGES <= WIN");
    end

    cnt_t win_cnt_q, win_cnt_d;
    cnt_t edge_acc_q, edge_acc_d;
    cnt_t edge_cnt_q, edge_cnt_d;
    cnt_t clean_cnt_q, clean_cnt_d;
    logic first_win_q, first_win_d;
    logic win_evt_q, win_evt_d;
    logic period_err_q, period_err_d;
    logic count_err_q, count_err_d;
    logic locked_q, locked_d;

    logic rise, per_evt, wrap, cnt_evt;
    cnt_t close_cnt, period_last;

    edge_period_meter u_meter (
        .clk_in        (clk_in),
        .rst           (rst),
        .div_clk_i     (mon.div_clk),
        .en_i          (mon.en),
        .rise_o        (rise),
        .per_evt_o     (per_evt),
        .period_last_o (period_last)
    );

    assign wrap      = mon.en && (win_cnt_q == WIN_LAST);
    // A rise in the wrap cycle belongs to the window that is closing.
    assign close_cnt = edge_acc_q + cnt_t'(rise);
    assign cnt_evt   = wrap && first_win_q && (close_cnt != EXP_C);

    always_comb begin
        win_cnt_d   = win_cnt_q;
        edge_acc_d  = edge_acc_q;
        edge_cnt_d  = edge_cnt_q;
        clean_cnt_d = clean_cnt_q;
        first_win_d = first_win_q;
        win_evt_d   = win_evt_q;
        // A new error beats a simultaneous clear.
        period_err_d = per_evt | (period_err_q & ~mon.clr);
        count_err_d  = cnt_evt | (count_err_q & ~mon.clr);
        if (!mon.en) begin
            win_cnt_d   = '0;
            edge_acc_d  = '0;
            clean_cnt_d = '0;
            first_win_d = 1'b0;
            win_evt_d   = 1'b0;
        end else begin
            win_cnt_d  = wrap ? '0 : win_cnt_q + ONE_C;
            edge_acc_d = wrap ? '0 : close_cnt;
            win_evt_d  = wrap ? 1'b0 : (win_evt_q | per_evt);
            if (wrap) begin
                edge_cnt_d  = close_cnt;
                first_win_d = 1'b1;
            end
            if (per_evt) begin
                clean_cnt_d = '0;
            end else if (wrap && first_win_q) begin
                if (cnt_evt || win_evt_q) begin
                    clean_cnt_d = '0;
                end else if (clean_cnt_q != LOCK_C) begin
                    clean_cnt_d = clean_cnt_q + ONE_C;
                end
            end
        end
        locked_d = (clean_cnt_d == LOCK_C);
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            win_cnt_q    <= '0;
            edge_acc_q   <= '0;
            edge_cnt_q   <= '0;
            clean_cnt_q  <= '0;
            first_win_q  <= 1'b0;
            win_evt_q    <= 1'b0;
            period_err_q <= 1'b0;
            count_err_q  <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            win_cnt_q    <= win_cnt_d;
            edge_acc_q   <= edge_acc_d;
            edge_cnt_q   <= edge_cnt_d;
            clean_cnt_q  <= clean_cnt_d;
            first_win_q  <= first_win_d;
            win_evt_q    <= win_evt_d;
            period_err_q <= period_err_d;
            count_err_q  <= count_err_d;
            locked_q     <= locked_d;
        end
    end

    assign mon.period_last = period_last;
    assign mon.edge_cnt    = edge_cnt_q;
    assign mon.win_done    = wrap;
    assign mon.period_err  = period_err_q;
    assign mon.count_err   = count_err_q;
    assign mon.locked      = locked_q;
endmodule

// File: tb/tb_div_clk_monitor.sv
// tb/tb_div_clk_monitor.sv - self-checking bench for div_clk_monitor
module tb_div_clk_monitor;
    import div_pkg::*;

    localparam int W    = int'(WIN);
    localparam int EXPN = int'(EXP_EDGES);
    localparam int PMIN = int'(MIN_PER);
    localparam int PMAX = int'(MAX_PER);
    localparam int LOCK = int'(LOCK_WINS);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    div_clk_monitor_if bus ();

    div_clk_monitor dut (
        .clk_in (clk),
        .rst    (rst_n),
        .mon    (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // 2/4 mix divider, 22 cycles: nine period-2 pulses then one period-4 pulse.
    function automatic logic pat(input int i);
        int p;
        p = i % 22;
        if (p < 18) return (p % 2) == 0;
        return p < 20;
    endfunction

    // Reference model: rises are tracked by their cycle index since enable,
    // periods are index differences and windows are index ranges.
    int   m_t, m_last_rise, m_last_evt, m_run;
    int   m_rises[$];
    logic m_prev;
    int   e_period_last, e_edge_cnt;
    logic e_period_err, e_count_err, e_locked, e_win_done;

    always @(negedge clk) begin
        logic rise_now, evt, cevt;
        int   p, n, k;
        if (!rst_n) begin
            m_t = 0; m_last_rise = -1; m_last_evt = -1; m_run = 0;
            m_rises.delete(); m_prev = 1'b0;
            e_period_last = 0; e_edge_cnt = 0;
            e_period_err = 1'b0; e_count_err = 1'b0; e_locked = 1'b0;
        end
        e_win_done = rst_n && bus.en && ((m_t % W) == W - 1);

        check("period_last", int'(bus.period_last), e_period_last);
        check("edge_cnt",    int'(bus.edge_cnt),    e_edge_cnt);
        check("win_done",    int'(bus.win_done),    int'(e_win_done));
        check("period_err",  int'(bus.period_err),  int'(e_period_err));
        check("count_err",   int'(bus.count_err),   int'(e_count_err));
        check("locked",      int'(bus.locked),      int'(e_locked));

        if (rst_n) begin
            rise_now = bus.div_clk && !m_prev;
            evt  = 1'b0;
            cevt = 1'b0;
            if (!bus.en) begin
                m_t = 0; m_last_rise = -1; m_last_evt = -1; m_run = 0;
                m_rises.delete();
                e_locked = 1'b0;
            end else begin
                if (rise_now) begin
                    if (m_last_rise >= 0) begin
                        p = m_t - m_last_rise;
                        e_period_last = (p > 255) ? 255 : p;
                        if (p < PMIN || p > PMAX) evt = 1'b1;
                    end
                    m_last_rise = m_t;
                    m_rises.push_back(m_t);
                end else if (m_last_rise >= 0 && (m_t - m_last_rise) == PMAX + 1) begin
                    evt = 1'b1;
                end
                if (evt) begin
                    m_last_evt = m_t;
                    m_run = 0;
                end
                if ((m_t % W) == W - 1) begin
                    k = m_t / W;
                    n = 0;
                    foreach (m_rises[i]) if (m_rises[i] / W == k) n++;
                    m_rises.delete();
                    e_edge_cnt = n;
                    if (k >= 1) begin
                        if (n != EXPN) cevt = 1'b1;
                        if (n != EXPN || (m_last_evt >= 0 && m_last_evt / W == k)) m_run = 0;
                        else m_run++;
                    end
                end
                e_locked = (m_run >= LOCK);
                m_t++;
            end
            e_period_err = evt  ? 1'b1 : (bus.clr ? 1'b0 : e_period_err);
            e_count_err  = cevt ? 1'b1 : (bus.clr ? 1'b0 : e_count_err);
            m_prev = bus.div_clk;
        end
    end

    task automatic drive(input logic r, input logic d, input logic e, input logic c);
        @(posedge clk);
        #1;
        rst_n       = r;
        bus.div_clk = d;
        bus.en      = e;
        bus.clr     = c;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_period_last"}, int'(bus.period_last), 0);
        check({tag, "_edge_cnt"},    int'(bus.edge_cnt),    0);
        check({tag, "_win_done"},    int'(bus.win_done),    0);
        check({tag, "_period_err"},  int'(bus.period_err),  0);
        check({tag, "_count_err"},   int'(bus.count_err),   0);
        check({tag, "_locked"},      int'(bus.locked),      0);
    endtask

    initial begin
        logic dv;
        bus.div_clk = 1'b0;
        bus.en      = 1'b0;
        bus.clr     = 1'b0;
        repeat (2) @(posedge clk);
        #4;
        check_all_zero("reset");

        // Divider running from reset, then stuck low after the rise at cycle 110.
        for (int c = 0; c < 116; c++) begin
            drive(1'b1, (c >= 111) ? 1'b0 : pat(c), 1'b1, 1'b0);
            #3;
            if (c == 22) check("w1_edge_cnt", int'(bus.edge_cnt), 10);
            if (c == 63) check("period_last_2", int'(bus.period_last), 2);
            if (c == 65) begin
                check("w3_win_done", int'(bus.win_done), 1);
                check("w3_not_locked_yet", int'(bus.locked), 0);
            end
            if (c == 66) begin
                check("w3_locked", int'(bus.locked), 1);
                check("w3_edge_cnt", int'(bus.edge_cnt), 10);
                check("clean_period_err", int'(bus.period_err), 0);
                check("clean_count_err", int'(bus.count_err), 0);
            end
            if (c == 67) check("period_last_4", int'(bus.period_last), 4);
            if (c == 115) begin
                check("stuck_pre_err", int'(bus.period_err), 0);
                check("stuck_pre_locked", int'(bus.locked), 1);
            end
        end

        // Stuck detection, late rises and clr interaction.
        for (int c = 116; c < 164; c++) begin
            drive(1'b1, (c == 142 || c == 147), 1'b1, (c == 144 || c == 147 || c == 150));
            #3;
            if (c == 116) begin
                check("stuck_period_err", int'(bus.period_err), 1);
                check("stuck_locked_drop", int'(bus.locked), 0);
            end
            if (c == 132) begin
                check("stuck_win_edge_cnt", int'(bus.edge_cnt), 1);
                check("stuck_win_count_err", int'(bus.count_err), 1);
            end
            if (c == 143) check("long_period_last", int'(bus.period_last), 32);
            if (c == 145) begin
                check("clr_period_err", int'(bus.period_err), 0);
                check("clr_count_err", int'(bus.count_err), 0);
            end
            if (c == 148) begin
                check("clr_vs_err_wins", int'(bus.period_err), 1);
                check("period5_last", int'(bus.period_last), 5);
            end
            if (c == 151) check("clr_again", int'(bus.period_err), 0);
        end

        // Reset at win_cnt=10.
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        #3;
        check_all_zero("midreset");
        drive(1'b0, 1'b0, 1'b1, 1'b0);

        // Late start with a rise on the wrap cycle, en dropout, then a fast clock.
        dv = 1'b0;
        for (int c = 0; c < 168; c++) begin
            if (c < 5)         dv = 1'b0;
            else if (c >= 143) dv = ~dv;
            else               dv = pat(c + 1);
            drive(1'b1, dv, !(c >= 70 && c <= 76), 1'b0);
            #3;
            if (c == 22) begin
                check("unchecked_edge_cnt", int'(bus.edge_cnt), 8);
                check("unchecked_count_err", int'(bus.count_err), 0);
            end
            if (c == 44) begin
                check("wrap_edge_cnt", int'(bus.edge_cnt), 10);
                check("wrap_not_locked", int'(bus.locked), 0);
            end
            if (c == 66) check("relock_after_reset", int'(bus.locked), 1);
            if (c == 71) check("en_low_locked", int'(bus.locked), 0);
            if (c == 142) check("en_relock_pending", int'(bus.locked), 0);
            if (c == 143) check("en_relock", int'(bus.locked), 1);
            if (c == 165) begin
                check("fast_edge_cnt", int'(bus.edge_cnt), 11);
                check("fast_count_err", int'(bus.count_err), 1);
                check("fast_locked", int'(bus.locked), 0);
            end
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
